rv_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core. It time-shares one ALU and one unified instruction/data memory port across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK phases. It replaces the single-cycle opcode decoder with a Moore state machine that produces per-cycle datapath enables. It also owns the memory handshake, a memory timeout, and illegal-opcode trapping.

---
 rtl/rv_pkg.sv | 89 ++++++++
 rtl/rv_mem_wait_timer.sv | 34 +++
 rtl/rv_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: opcodes, FSM states,
// datapath mux selects and trap causes.
package rv_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Sequencer states; the numeric value is what appears on state_o
    typedef logic [3:0] state_t;
    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_EXEC_R   = 4'd3;
    localparam state_t S_EXEC_I   = 4'd4;
    localparam state_t S_MEM_ADDR = 4'd5;
    localparam state_t S_MEM_RD   = 4'd6;
    localparam state_t S_MEM_WR   = 4'd7;
    localparam state_t S_LOAD_WB  = 4'd8;
    localparam state_t S_ALU_WB   = 4'd9;
    localparam state_t S_BRANCH   = 4'd10;
    localparam state_t S_JAL      = 4'd11;
    localparam state_t S_JALR     = 4'd12;
    localparam state_t S_LUI      = 4'd13;
    localparam state_t S_AUIPC    = 4'd14;
    localparam state_t S_TRAP     = 4'd15;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    // Register-file write-back source
    localparam logic [1:0] RESULT_SRC_ALUOUT = 2'd0;
    localparam logic [1:0] RESULT_SRC_MDR    = 2'd1;
    localparam logic [1:0] RESULT_SRC_OLDPC4 = 2'd2;

    // Next-PC source
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // Dispatch target out of DECODE; unknown opcodes land in TRAP
    function automatic state_t decode_target(input logic [6:0] op);
        state_t s;
        case (op)
            OP_R:                s = S_EXEC_R;
            OP_I:                s = S_EXEC_I;
            OP_LOAD, OP_STORE:   s = S_MEM_ADDR;
            OP_BRANCH:           s = S_BRANCH;
            OP_JAL:              s = S_JAL;
            OP_JALR:             s = S_JALR;
            OP_LUI:              s = S_LUI;
            OP_AUIPC:            s = S_AUIPC;
            default:             s = S_TRAP;
        endcase
        return s;
    endfunction

    // States that hold a memory request open
    function automatic logic is_req_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/rv_mem_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags when the
// request has waited its last allowed cycle.
module rv_mem_wait_timer #(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,     // start of a new request, or request completed
    input  logic busy,      // request pending and memory not ready
    output logic expired,   // this is the final cycle the request may wait
    output logic fresh      // no stall cycles counted yet for this request
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] ONE   = TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] count_reg;

    // Clear has priority over counting so a new request always starts at zero
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (busy) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign expired = (count_reg == LIMIT);
    assign fresh   = (count_reg == '0);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: Moore FSM producing per-cycle datapath
// enables, memory handshake with timeout, and illegal-opcode trapping.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       old_pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [3:0] state_o,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t     state_reg, state_next;
    logic [1:0] cause_reg, cause_next;
    logic       timer_clear, timer_busy, timer_expired, timer_fresh;

    // A request restarts its wait budget on entry and once it completes
    assign timer_clear = ((state_next != state_reg) && is_req_state(state_next))
                       || (mem_req && mem_ready);
    assign timer_busy  = mem_req && !mem_ready;

    rv_mem_wait_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .srst    (rst),
        .clear   (timer_clear),
        .busy    (timer_busy),
        .expired (timer_expired),
        .fresh   (timer_fresh)
    );

    // State and trap-cause registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cause_reg <= CAUSE_NONE;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
        end
    end

    // Next-state logic; memory completion beats both abort and timeout
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (!run && timer_fresh) begin
                    // Only a request that has not yet stalled may be withdrawn
                    state_next = S_IDLE;
                end else if (timer_expired) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                state_next = decode_target(opcode);
                if (decode_target(opcode) == S_TRAP) cause_next = CAUSE_ILLEGAL;
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: begin
                state_next = S_ALU_WB;
            end
            S_MEM_ADDR: begin
                state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    state_next = (state_reg == S_MEM_RD) ? S_LOAD_WB : S_FETCH;
                end else if (timer_expired) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JAL, S_JALR: begin
                state_next = S_FETCH;
            end
            default: begin
                // TRAP holds until reset
                state_next = S_TRAP;
            end
        endcase
    end

    // Moore output decode; FETCH's IR/PC loads wait for mem_ready
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_src     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_ALU;
        old_pc_write = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        result_src   = RESULT_SRC_ALUOUT;
        case (state_reg)
            S_FETCH: begin
                mem_req      = 1'b1;
                alu_src_a    = SRC_A_PC;
                alu_src_b    = SRC_B_FOUR;
                alu_op       = ALU_ADD;
                ir_write     = mem_ready;
                old_pc_write = mem_ready;
                pc_write     = mem_ready;
                pc_src       = PC_SRC_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_PASSB;
            end
            S_AUIPC: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                result_src = RESULT_SRC_ALUOUT;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
            end
            S_LOAD_WB: begin
                reg_write  = 1'b1;
                result_src = RESULT_SRC_MDR;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_CMP;
                pc_write  = br_taken;
                pc_src    = PC_SRC_ALUOUT;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                result_src = RESULT_SRC_OLDPC4;
                pc_write   = 1'b1;
                pc_src     = PC_SRC_ALUOUT;
            end
            S_JALR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_ADD;
                reg_write  = 1'b1;
                result_src = RESULT_SRC_OLDPC4;
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JALR;
            end
            default: begin
                // IDLE and TRAP keep every enable low
            end
        endcase
    end

    assign state_o    = state_reg;
    assign trap       = (state_reg == S_TRAP);
    assign trap_cause = cause_reg;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl. Each instruction is expanded
// into its expected per-cycle phase trace (from opcode and memory wait counts),
// then replayed against the DUT cycle by cycle.
module tb_rv_multicycle_ctrl;
    import rv_pkg::*;

    localparam int TO = 4;

    logic       clk, rst, run, br_taken, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_we, addr_src, ir_write, pc_write, old_pc_write;
    logic       reg_write, trap;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
    logic [3:0] state_o;
    logic [19:0] obs_ctl;

    int    vectors    = 0;
    int    miscompares = 0;
    string cur_tag    = "init";
    bit    trapped    = 0;

    typedef struct {
        logic       run;
        logic       rdy;
        logic       bt;
        logic [6:0] opc;
        logic [3:0] st;
        logic [19:0] ctl;
    } rec_t;
    rec_t q[$];

    rv_multicycle_ctrl #(.TIMEOUT_W(8), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .br_taken(br_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_src(addr_src), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .old_pc_write(old_pc_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .result_src(result_src), .state_o(state_o), .trap(trap),
        .trap_cause(trap_cause)
    );

    assign obs_ctl = {mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
                      old_pc_write, alu_src_a, alu_src_b, alu_op, reg_write,
                      result_src, trap, trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ctl(
        input logic req, input logic we, input logic asrc, input logic irw,
        input logic pcw, input logic [1:0] psrc, input logic opw,
        input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
        input logic rw, input logic [1:0] rs, input logic tr, input logic [1:0] tc);
        return {req, we, asrc, irw, pcw, psrc, opw, a, b, op, rw, rs, tr, tc};
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == OP_R || o == OP_I || o == OP_LOAD || o == OP_STORE ||
               o == OP_BRANCH || o == OP_JAL || o == OP_JALR || o == OP_LUI ||
               o == OP_AUIPC;
    endfunction

    function automatic int rnd_wait();
        int r;
        r = int'($urandom_range(0, 19));
        return (r < 13) ? 0 : (r - 13);
    endfunction

    task automatic add(input logic [3:0] st, input logic [19:0] c, input logic rdy,
                       input logic bt, input logic [6:0] opc, input logic rn);
        rec_t r;
        r.run = rn; r.rdy = rdy; r.bt = bt; r.opc = opc; r.st = st; r.ctl = c;
        q.push_back(r);
    endtask

    task automatic check(input logic [3:0] st, input logic [19:0] c);
        vectors++;
        assert (state_o === st) else begin
            miscompares++;
            $error("FAIL %s state: observed=%0d expected=%0d", cur_tag, state_o, st);
        end
        vectors++;
        assert (obs_ctl === c) else begin
            miscompares++;
            $error("FAIL %s ctl(st=%0d): observed=%05h expected=%05h", cur_tag, st, obs_ctl, c);
        end
    endtask

    // Replays queued cycles: drive inputs, settle, compare, advance one clock
    task automatic play();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            run = r.run; mem_ready = r.rdy; br_taken = r.bt; opcode = r.opc;
            #1;
            check(r.st, r.ctl);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input logic rn);
        rst = 1'b1; run = rn; mem_ready = 1'($urandom);
        @(posedge clk); #1;
        rst = 1'b0;
        cur_tag = "reset";
        check(S_IDLE, 20'h0);
        trapped = 0;
        add(S_IDLE, 20'h0, 1'($urandom), 1'($urandom), opcode, 1'b1);
    endtask

    task automatic trap_tail(input logic [1:0] cause, input logic [6:0] opc);
        for (int i = 0; i < 20; i++)
            add(S_TRAP, ctl(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,0,2'd0,1,cause),
                1'($urandom), 1'($urandom), opc, 1'b1);
        trapped = 1;
    endtask

    // Request phase: w stalled cycles before ready; TO stalls exhaust the budget
    task automatic req_phase(input logic [3:0] st, input int w, input logic [6:0] opc);
        logic [19:0] c_wait, c_done;
        if (st == S_FETCH) begin
            c_wait = ctl(1,0,0,0,0,2'd0,0,2'd0,2'd2,2'd0,0,2'd0,0,2'd0);
            c_done = ctl(1,0,0,1,1,2'd0,1,2'd0,2'd2,2'd0,0,2'd0,0,2'd0);
        end else begin
            c_wait = ctl(1,(st == S_MEM_WR),1,0,0,2'd0,0,2'd0,2'd0,2'd0,0,2'd0,0,2'd0);
            c_done = c_wait;
        end
        for (int i = 0; i < w && i < TO; i++)
            add(st, c_wait, 1'b0, 1'($urandom), opc, 1'b1);
        if (w >= TO) trap_tail(CAUSE_TIMEOUT, opc);
        else         add(st, c_done, 1'b1, 1'($urandom), opc, 1'b1);
    endtask

    // Expected trace for one instruction starting in FETCH
    task automatic instr(input logic [6:0] opc, input int wf, input int wm, input int btm);
        logic b;
        b = (btm == 2) ? 1'($urandom) : 1'(btm);
        req_phase(S_FETCH, wf, opc);
        if (trapped) return;
        add(S_DECODE, ctl(0,0,0,0,0,2'd0,0,2'd1,2'd1,2'd0,0,2'd0,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
        case (opc)
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
                if (opc == OP_R)
                    add(S_EXEC_R, ctl(0,0,0,0,0,2'd0,0,2'd2,2'd0,2'd2,0,2'd0,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
                else if (opc == OP_I)
                    add(S_EXEC_I, ctl(0,0,0,0,0,2'd0,0,2'd2,2'd1,2'd2,0,2'd0,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
                else if (opc == OP_LUI)
                    add(S_LUI, ctl(0,0,0,0,0,2'd0,0,2'd3,2'd1,2'd3,0,2'd0,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
                else
                    add(S_AUIPC, ctl(0,0,0,0,0,2'd0,0,2'd1,2'd1,2'd0,0,2'd0,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
                add(S_ALU_WB, ctl(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,1,2'd0,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
            end
            OP_LOAD, OP_STORE: begin
                add(S_MEM_ADDR, ctl(0,0,0,0,0,2'd0,0,2'd2,2'd1,2'd0,0,2'd0,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
                req_phase((opc == OP_STORE) ? S_MEM_WR : S_MEM_RD, wm, opc);
                if (!trapped && opc == OP_LOAD)
                    add(S_LOAD_WB, ctl(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,1,2'd1,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
            end
            OP_BRANCH:
                add(S_BRANCH, ctl(0,0,0,0,b,2'd1,0,2'd2,2'd0,2'd1,0,2'd0,0,2'd0), 1'($urandom), b, opc, 1'b1);
            OP_JAL:
                add(S_JAL, ctl(0,0,0,0,1,2'd1,0,2'd0,2'd0,2'd0,1,2'd2,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
            OP_JALR:
                add(S_JALR, ctl(0,0,0,0,1,2'd2,0,2'd2,2'd1,2'd0,1,2'd2,0,2'd0), 1'($urandom), 1'($urandom), opc, 1'b1);
            default:
                trap_tail(CAUSE_ILLEGAL, opc);
        endcase
    endtask

    task automatic run_instr(input string tag, input logic [6:0] opc, input int wf,
                             input int wm, input int btm);
        cur_tag = tag;
        instr(opc, wf, wm, btm);
        play();
        if (trapped) begin
            do_reset(1'($urandom));
            play();
        end
    endtask

    initial begin
        logic [6:0] legal [9];
        logic [6:0] opc;
        int idx;
        legal = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        rst = 1'b1; run = 1'b0; br_taken = 1'b0; mem_ready = 1'b0; opcode = 7'h0;
        @(posedge clk); #1;
        do_reset(1'b0);
        q.delete();
        // IDLE holds while run is low, then starts fetching
        add(S_IDLE, 20'h0, 1'b1, 1'b0, 7'h0, 1'b0);
        add(S_IDLE, 20'h0, 1'b0, 1'b0, 7'h0, 1'b1);
        cur_tag = "idle"; play();

        run_instr("r_add",      OP_R,      0, 0, 0);
        run_instr("load_wait3", OP_LOAD,   0, 3, 0);
        run_instr("br_taken",   OP_BRANCH, 0, 0, 1);
        run_instr("br_not",     OP_BRANCH, 0, 0, 0);

        // Fresh fetch withdrawn when run drops
        add(S_FETCH, ctl(1,0,0,0,0,2'd0,0,2'd0,2'd2,2'd0,0,2'd0,0,2'd0), 1'b0, 1'b0, OP_R, 1'b0);
        add(S_IDLE, 20'h0, 1'b1, 1'b0, OP_R, 1'b1);
        cur_tag = "fetch_abort"; play();

        run_instr("fetch_timeout", OP_R, 4, 0, 0);
        run_instr("fetch_ready4",  OP_I, 3, 0, 0);
        run_instr("store_wait3",   OP_STORE, 0, 3, 0);

        // Reset in the middle of a stalled store
        cur_tag = "rst_mid_store";
        instr(OP_STORE, 0, 3, 0);
        void'(q.pop_back());
        void'(q.pop_back());
        play();
        do_reset(1'b1);
        play();

        run_instr("illegal", 7'b1111111, 0, 0, 0);
        run_instr("jal",     OP_JAL,   0, 0, 0);
        run_instr("jalr",    OP_JALR,  1, 0, 0);
        run_instr("lui",     OP_LUI,   0, 0, 0);
        run_instr("auipc",   OP_AUIPC, 2, 0, 0);
        run_instr("store",   OP_STORE, 0, 0, 0);
        run_instr("load_to", OP_LOAD,  0, 4, 0);

        for (int n = 0; n < 250; n++) begin
            idx = int'($urandom_range(0, 9));
            if (idx < 9) opc = legal[idx];
            else begin
                opc = 7'($urandom);
                while (is_legal(opc)) opc = 7'($urandom);
            end
            run_instr($sformatf("rnd%0d_op%b", n, opc), opc, rnd_wait(), rnd_wait(), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
